lsu_mem_initiator: RTL and testbench
====================================

# lsu_mem_initiator

Load/store initiator between the core's memory stage and the data memory. Accepts one load or store per handshake and converts the byte address and funct3 into word-aligned memory requests with byte enables. Lane-aligns and sign- or zero-extends load data, and splits misaligned accesses into two word transactions. Each operation returns a single response pulse to the core.

## Interface
- ADDR_W, 32, byte-address width
- ALLOW_SPLIT, 1, 1 = split misaligned accesses into two words; 0 = report them as errors
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_rvalid  in  1  read data valid, at least 1 cycle after acceptance
- mem_rdata  in  32  read word
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned (ALLOW_SPLIT=0) or illegal funct3

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE, on req_valid: latch addr, we, funct3 and wdata.
  - Illegal funct3 -> RESP with err=1 and no memory access.
  - Illegal loads: 011, 110, 111. Illegal stores: anything other than 000/001/010.
- Access span: offset = addr[1:0]; size = 1/2/4 bytes. The access spans two words when offset + size > 4.
  - Spanning with ALLOW_SPLIT=0 -> RESP with err=1 and no access.
- ISSUE0: mem_req_valid=1 with word = addr[ADDR_W-1:2].
  - mem_be = the size-bit mask shifted left by offset, truncated to 4 bits.
  - mem_wdata = wdata << 8*offset.
  - On mem_req_ready: store -> ISSUE1 if split, else RESP; load -> WAIT0.
- WAIT0: on mem_rvalid, capture the word -> ISSUE1 if split, else RESP.
- ISSUE1: next word (word+1, wraps modulo 2^(ADDR_W-2)).
  - mem_be = the remaining bytes, starting at lane 0.
  - mem_wdata = wdata >> 8*(4-offset).
  - Store -> RESP; load -> WAIT1.
- WAIT1: on mem_rvalid, capture the second word -> RESP.
- RESP: resp_valid=1 for one cycle -> IDLE.
- Load data: the byte stream is {word1, word0} >> 8*offset.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: unmodified.
- mem_rvalid outside WAIT0/WAIT1 is ignored.

## Timing
- Reset values: state IDLE, req_ready=1, mem_req_valid=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Memory request outputs are registered, stable while mem_req_valid=1 and mem_req_ready=0, and deassert the cycle after acceptance.
- With zero-wait memory (ready=1, rvalid 1 cycle after acceptance), accept at cycle 0:
  - Aligned store: resp at cycle 2.
  - Aligned load: resp at cycle 3.
  - Split load: resp at cycle 5.
  - Error: resp at cycle 1.
- Each extra cycle of mem_req_ready low or mem_rvalid latency adds one cycle.
- Throughput: one operation in flight. The next request is accepted the cycle after RESP.
- Reset mid-operation: immediate return to IDLE and all outputs to their reset values. The in-flight operation produces no response, and a half-issued split store is not completed.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum.
  - Size decode function: funct3 -> byte count.
- Sub-module lsu_align, purely combinational: offset + funct3 -> mem_be and shifted wdata, plus the load merge/extend. Shared by both issue paths.
- FSM, handshake and capture registers stay in the top module.

## Test plan
- Aligned LW at 0x100: accept, mem_rdata=0xDEADBEEF, 1-cycle rvalid -> mem_addr=0x100, be=1111, resp_rdata=0xDEADBEEF at cycle 3, err=0.
- LB at 0x103, word 0x80FF_FFFF -> be=1000, resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH 0xABCD at 0x202 -> be=1100, mem_wdata=0xABCD0000, resp_valid at cycle 2.
- Split LW at 0x0FE with words 0x1122_3344 then 0x5566_7788 -> requests at 0x0FC (be=1100) and 0x100 (be=0011), resp_rdata=0x7788_1122. With ALLOW_SPLIT=0 -> err=1 and no mem_req_valid.
- Backpressure: mem_req_ready low for 3 cycles on SW 0x12345678 at 0x40 -> outputs held constant for those cycles, resp 3 cycles later than nominal.
- Reset low during WAIT0 of a load, with a stray mem_rvalid after release -> no resp_valid, req_ready=1, and the stray rvalid is ignored. Illegal funct3 111 -> err=1 at cycle 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator:
// funct3 codes, FSM state encoding and size/legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Access size in bytes; only meaningful for legal funct3 values.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        logic [2:0] sz;
        case (f3[1:0])
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            default: sz = 3'd4;
        endcase
        return sz;
    endfunction

    // Byte-enable mask for the access, lane 0 justified.
    function automatic logic [3:0] f3_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3_size(f3))
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Stores only have signed-width encodings; loads add BU/HU.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment datapath, purely combinational.
// Ports: off_i/funct3_i select the access; wdata_i is LSB-justified
// store data; be0_o/wdata0_o drive the first word, be1_o/wdata1_o the
// second word of a split; lo_i/hi_i are the two read words and rdata_o
// is the aligned, extended load result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  sh;
    logic [7:0]  be_w;
    logic [63:0] wd_w;
    logic [31:0] raw;

    assign sh = {off_i, 3'b000};

    // Shifting across an 8-lane / 64-bit window yields both words at
    // once: the low half feeds the first word, the spill the second.
    assign be_w     = {4'b0000, f3_mask(funct3_i)} << off_i;
    assign be0_o    = be_w[3:0];
    assign be1_o    = be_w[7:4];

    assign wd_w     = {32'h0, wdata_i} << sh;
    assign wdata0_o = wd_w[31:0];
    assign wdata1_o = wd_w[63:32];

    assign raw = 32'({hi_i, lo_i} >> sh);

    always_comb begin
        rdata_o = raw;
        case (funct3_i)
            F3_B:    rdata_o = {{24{raw[7]}}, raw[7:0]};
            F3_H:    rdata_o = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   rdata_o = {24'h0, raw[7:0]};
            F3_HU:   rdata_o = {16'h0, raw[15:0]};
            default: rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one core request in, one or two word-aligned
// memory transactions out, one response pulse back.
// Ports: req_* core request (valid/ready), mem_req_* registered memory
// request (valid/ready), mem_rvalid/mem_rdata read return,
// resp_* one-cycle completion with load data and error flag.
module lsu_mem_initiator #(
    parameter int ADDR_W      = 32,
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    import lsu_pkg::*;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [31:0]         wdata_q;
    logic [31:0]         word0_q;
    logic                split_q;

    logic                mem_req_valid_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [31:0]         mem_wdata_q;
    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_err_q;

    logic                idle;
    logic [1:0]          a_off;
    logic [2:0]          a_f3;
    logic [31:0]         a_wdata;
    logic [31:0]         a_lo;
    logic [31:0]         a_hi;
    logic [3:0]          be0;
    logic [3:0]          be1;
    logic [31:0]         wd0;
    logic [31:0]         wd1;
    logic [31:0]         ld_data;

    logic [3:0]          span_end;
    logic                req_spans;
    logic                req_ok;
    logic [ADDR_W-3:0]   word_nx;

    assign idle = (state_q == ST_IDLE);

    // The first word is loaded on acceptance, before the capture
    // registers hold the request, so the aligner looks at the live
    // request in IDLE and at the latched copy afterwards.
    assign a_off   = idle ? req_addr[1:0] : addr_q[1:0];
    assign a_f3    = idle ? req_funct3    : f3_q;
    assign a_wdata = idle ? req_wdata     : wdata_q;

    assign a_lo = (state_q == ST_WAIT1) ? word0_q   : mem_rdata;
    assign a_hi = (state_q == ST_WAIT1) ? mem_rdata : 32'h0;

    lsu_align u_align (
        .off_i    (a_off),
        .funct3_i (a_f3),
        .wdata_i  (a_wdata),
        .lo_i     (a_lo),
        .hi_i     (a_hi),
        .be0_o    (be0),
        .be1_o    (be1),
        .wdata0_o (wd0),
        .wdata1_o (wd1),
        .rdata_o  (ld_data)
    );

    assign span_end  = {2'b00, req_addr[1:0]}
                     + {1'b0, f3_size(req_funct3)};
    assign req_spans = (span_end > 4'd4);
    assign req_ok    = f3_legal(req_we, req_funct3)
                     && !(req_spans && (ALLOW_SPLIT == 1'b0));

    // Second word wraps within the word-address space.
    assign word_nx = addr_q[ADDR_W-1:2]
                   + {{(ADDR_W-3){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            we_q            <= 1'b0;
            f3_q            <= 3'b000;
            wdata_q         <= 32'h0;
            word0_q         <= 32'h0;
            split_q         <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_be_q        <= 4'b0000;
            mem_wdata_q     <= 32'h0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0;
            resp_err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        wdata_q <= req_wdata;
                        split_q <= req_spans;
                        if (!req_ok) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q         <= ST_ISSUE0;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= req_we;
                            mem_addr_q      <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be_q        <= be0;
                            mem_wdata_q     <= wd0;
                        end
                    end
                end
                ST_ISSUE0: begin
                    if (mem_req_ready) begin
                        if (we_q && split_q) begin
                            // Back-to-back: second store word follows
                            // immediately as a fresh request.
                            state_q     <= ST_ISSUE1;
                            mem_addr_q  <= {word_nx, 2'b00};
                            mem_be_q    <= be1;
                            mem_wdata_q <= wd1;
                        end else if (we_q) begin
                            state_q         <= ST_RESP;
                            mem_req_valid_q <= 1'b0;
                            mem_we_q        <= 1'b0;
                            mem_be_q        <= 4'b0000;
                            resp_valid_q    <= 1'b1;
                            resp_rdata_q    <= 32'h0;
                        end else begin
                            state_q         <= ST_WAIT0;
                            mem_req_valid_q <= 1'b0;
                            mem_be_q        <= 4'b0000;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (mem_rvalid) begin
                        if (split_q) begin
                            state_q         <= ST_ISSUE1;
                            word0_q         <= mem_rdata;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= 1'b0;
                            mem_addr_q      <= {word_nx, 2'b00};
                            mem_be_q        <= be1;
                            mem_wdata_q     <= wd1;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= ld_data;
                        end
                    end
                end
                ST_ISSUE1: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_we_q        <= 1'b0;
                        mem_be_q        <= 4'b0000;
                        if (we_q) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= ST_WAIT1;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ld_data;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = idle;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a reactive memory model,
// a response scoreboard and a second no-split instance.
module tb_lsu_mem_initiator;
    import lsu_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        ns_req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        req_ready, mem_req_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata, resp_rdata;
    logic [3:0]  mem_be;
    logic        resp_valid, resp_err;

    logic        ns_req_ready, ns_mem_req_valid, ns_mem_we;
    logic [31:0] ns_mem_addr, ns_mem_wdata, ns_resp_rdata;
    logic [3:0]  ns_mem_be;
    logic        ns_resp_valid, ns_resp_err;

    int checks = 0;
    int fails = 0;
    int stall_left = 0;
    int rv_extra = 0;
    int rd_cnt = 0;
    int resp_cnt = 0;
    bit ns_seen = 1'b0;
    logic [31:0] rq[$];
    mreq_t       mlog[$];
    exp_t        sb[$];

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_W(32), .ALLOW_SPLIT(1'b1)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    lsu_mem_initiator #(.ADDR_W(32), .ALLOW_SPLIT(1'b0)) dut_ns (
        .clk(clk), .reset(rst_n),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(ns_mem_req_valid), .mem_req_ready(1'b1),
        .mem_we(ns_mem_we), .mem_addr(ns_mem_addr),
        .mem_be(ns_mem_be), .mem_wdata(ns_mem_wdata),
        .mem_rvalid(1'b0), .mem_rdata(32'h0),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata),
        .resp_err(ns_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) resp_cnt++;
        if (ns_mem_req_valid === 1'b1) ns_seen = 1'b1;
    end

    // Memory model: decides ready for the next edge, returns read data
    // 1 + rv_extra cycles after acceptance, logs accepted requests.
    initial begin : mem_model
        mreq_t cur;
        mreq_t snap;
        bit    stalled;
        stalled = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = (rq.size() > 0) ? rq.pop_front() : 32'h0;
                end
            end
            cur = '{mem_we, mem_addr, mem_be, mem_wdata};
            if (stalled) begin
                chk("hold_addr", cur.addr, snap.addr);
                chk("hold_wdata", cur.wdata, snap.wdata);
                chk("hold_ctl", 32'({mem_req_valid, cur.we, cur.be}),
                    32'({1'b1, snap.we, snap.be}));
            end
            if (mem_req_valid === 1'b1) begin
                if (stall_left > 0) begin
                    mem_req_ready = 1'b0;
                    stall_left--;
                    stalled = 1'b1;
                    snap = cur;
                end else begin
                    mem_req_ready = 1'b1;
                    stalled = 1'b0;
                    mlog.push_back(cur);
                    if (!cur.we) rd_cnt = 1 + rv_extra;
                end
            end else begin
                mem_req_ready = 1'b1;
                stalled = 1'b0;
            end
        end
    end

    task automatic run_op(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] erd,
                          input logic eerr, input int elat);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        sb.push_back('{erd, eerr, elat});
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = (resp_valid === 1'b1);
        end
        e = sb.pop_front();
        chk({tag, "_done"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_rdata"}, resp_rdata, e.rd);
            chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
            chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        end
    endtask

    task automatic chk_req(input string tag, input logic we,
                           input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
        mreq_t m;
        chk({tag, "_reqn"}, 32'(mlog.size() != 0), 32'd1);
        if (mlog.size() != 0) begin
            m = mlog.pop_front();
            chk({tag, "_addr"}, m.addr, addr);
            chk({tag, "_we_be"}, 32'({m.we, m.be}), 32'({we, be}));
            chk({tag, "_wdata"}, m.wdata, wd);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ctl", 32'({mem_req_valid, mem_we, mem_be}), 32'd0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        chk("rst_resp", 32'({resp_valid, resp_err}), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("ns_rst_ctl",
            32'({ns_req_ready, ns_mem_req_valid, ns_mem_we, ns_mem_be}),
            32'h40);
        chk("ns_rst_addr", ns_mem_addr | ns_mem_wdata, 32'h0);
        rst_n = 1'b1;

        rq.push_back(32'hDEADBEEF);
        run_op("lw", 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        chk_req("lw", 1'b0, 32'h100, 4'b1111, 32'h0);

        rq.push_back(32'h80FF_FFFF);
        run_op("lb", 1'b0, F3_B, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        chk_req("lb", 1'b0, 32'h100, 4'b1000, 32'h0);

        rq.push_back(32'h80FF_FFFF);
        run_op("lbu", 1'b0, F3_BU, 32'h103, 32'h0, 32'h00000080, 1'b0, 3);
        chk_req("lbu", 1'b0, 32'h100, 4'b1000, 32'h0);

        rq.push_back(32'h8001_0000);
        run_op("lh", 1'b0, F3_H, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 3);
        chk_req("lh", 1'b0, 32'h100, 4'b1100, 32'h0);

        rq.push_back(32'h8001_0000);
        run_op("lhu", 1'b0, F3_HU, 32'h102, 32'h0, 32'h00008001, 1'b0, 3);
        chk_req("lhu", 1'b0, 32'h100, 4'b1100, 32'h0);

        run_op("sh", 1'b1, F3_H, 32'h202, 32'h0000ABCD, 32'h0, 1'b0, 2);
        chk_req("sh", 1'b1, 32'h200, 4'b1100, 32'hABCD0000);

        rq.push_back(32'h1122_3344);
        rq.push_back(32'h5566_7788);
        run_op("lw_split", 1'b0, F3_W, 32'h0FE, 32'h0, 32'h77881122,
               1'b0, 5);
        chk_req("lw_split0", 1'b0, 32'h0FC, 4'b1100, 32'h0);
        chk_req("lw_split1", 1'b0, 32'h100, 4'b0011, 32'h0);

        run_op("sw_split", 1'b1, F3_W, 32'h3, 32'hAABBCCDD, 32'h0, 1'b0, 3);
        chk_req("sw_split0", 1'b1, 32'h0, 4'b1000, 32'hDD000000);
        chk_req("sw_split1", 1'b1, 32'h4, 4'b0111, 32'h00AABBCC);

        rq.push_back(32'hAB00_0000);
        rq.push_back(32'h0000_00CD);
        run_op("lh_wrap", 1'b0, F3_H, 32'hFFFFFFFF, 32'h0, 32'hFFFFCDAB,
               1'b0, 5);
        chk_req("lh_wrap0", 1'b0, 32'hFFFFFFFC, 4'b1000, 32'h0);
        chk_req("lh_wrap1", 1'b0, 32'h0, 4'b0001, 32'h0);

        stall_left = 3;
        run_op("sw_bp", 1'b1, F3_W, 32'h40, 32'h12345678, 32'h0, 1'b0, 5);
        chk_req("sw_bp", 1'b1, 32'h40, 4'b1111, 32'h12345678);

        run_op("ill_ld", 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        chk("ill_ld_noreq", 32'(mlog.size()), 32'd0);
        run_op("ill_st", 1'b1, F3_BU, 32'h10, 32'h55, 32'h0, 1'b1, 1);
        chk("ill_st_noreq", 32'(mlog.size()), 32'd0);

        @(negedge clk);
        chk("ns_rdy", 32'(ns_req_ready), 32'd1);
        ns_req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = F3_W;
        req_addr = 32'h0FE;
        @(posedge clk);
        #1;
        ns_req_valid = 1'b0;
        @(negedge clk);
        chk("ns_resp", 32'({ns_resp_valid, ns_resp_err}), 32'd3);
        chk("ns_rdata", ns_resp_rdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("ns_noreq", 32'(ns_seen), 32'd0);

        rv_extra = 6;
        rq.push_back(32'hBAD0BAD0);
        base = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = F3_W;
        req_addr = 32'h10;
        req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_ctl", 32'({mem_req_valid, mem_we, mem_be}), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_resp", 32'({resp_valid, resp_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv_extra = 0;
        repeat (10) @(negedge clk);
        chk("mid_rst_noresp", 32'(resp_cnt - base), 32'd0);
        chk("mid_rst_idle", 32'(req_ready), 32'd1);
        chk("stray_used", 32'(rq.size()), 32'd0);
        chk_req("mid_rst_ld", 1'b0, 32'h10, 4'b1111, 32'h0);

        rq.push_back(32'h0BADF00D);
        run_op("lw_after", 1'b0, F3_W, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 3);
        chk_req("lw_after", 1'b0, 32'h20, 4'b1111, 32'h0);

        chk("log_empty", 32'(mlog.size()), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
